// File: rtl/out_buf_drain_ctrl.sv
// Output-buffer drain controller: walks every compute unit of each finished accumulation
// buffer through the cluster read selects and streams the words on a valid/ready port.
`timescale 1ns/1ps
module out_buf_drain_ctrl #(
  parameter int OUTPUT_BUF_NUM   = 4,
  parameter int COMPUTE_UNIT_NUM = 4,
  parameter int OUTPUT_BUF_SIZE  = 32,
  parameter int RD_LAT           = 1
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic                                chunk_end_i,
  input  logic [$clog2(OUTPUT_BUF_NUM)-1:0]   acc_buf_sel_i,
  output logic [$clog2(OUTPUT_BUF_NUM)-1:0]   out_buf_sel_o,
  output logic [$clog2(COMPUTE_UNIT_NUM)-1:0] com_unit_out_buf_sel_o,
  input  logic [OUTPUT_BUF_SIZE-1:0]          out_buf_dat_i,
  output logic                                m_valid_o,
  input  logic                                m_ready_i,
  output logic [OUTPUT_BUF_SIZE-1:0]          m_data_o,
  output logic [$clog2(OUTPUT_BUF_NUM)-1:0]   m_buf_o,
  output logic [$clog2(COMPUTE_UNIT_NUM)-1:0] m_unit_o,
  output logic                                m_last_o,
  output logic [OUTPUT_BUF_NUM-1:0]           buf_busy_o,
  output logic                                overflow_o
);

  localparam int              BW        = $clog2(OUTPUT_BUF_NUM);
  localparam int              UW        = $clog2(COMPUTE_UNIT_NUM);
  localparam logic [UW-1:0]   UNIT_LAST = UW'(COMPUTE_UNIT_NUM - 1);
  localparam logic [1:0]      LAT_END   = 2'(RD_LAT);

  typedef enum logic [1:0] {IDLE, SEL, OUT} state_t;

  state_t                    state;
  logic [1:0]                lat_cnt;
  logic                      pend_vld;
  logic [BW-1:0]             pend_buf;

  logic                      hs;
  logic                      last_hs;
  logic                      req_ok;
  logic                      req_start;
  logic                      req_pend;
  logic                      req_drop;
  logic [OUTPUT_BUF_NUM-1:0] busy_nxt;

  // NOTE: every signal gets a value before any conditional update, so no latch is inferred.
  always_comb begin
    hs        = m_valid_o & m_ready_i;
    last_hs   = hs & (com_unit_out_buf_sel_o == UNIT_LAST);
    req_ok    = chunk_end_i & ~buf_busy_o[acc_buf_sel_i];
    req_start = req_ok & (state == IDLE);
    // A full pend slot frees up on the last handshake, so it can take a new request that cycle.
    req_pend  = req_ok & (state != IDLE) & (~pend_vld | last_hs);
    req_drop  = chunk_end_i & ~req_start & ~req_pend;
    busy_nxt  = buf_busy_o;
    if (last_hs) busy_nxt[out_buf_sel_o] = 1'b0;
    if (req_start | req_pend) busy_nxt[acc_buf_sel_i] = 1'b1;
  end

  // NOTE: state registers use non-blocking assignments so every update sees pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state                  <= IDLE;
      lat_cnt                <= '0;
      pend_vld               <= 1'b0;
      pend_buf               <= '0;
      out_buf_sel_o          <= '0;
      com_unit_out_buf_sel_o <= '0;
      m_valid_o              <= 1'b0;
      m_data_o               <= '0;
      m_buf_o                <= '0;
      m_unit_o               <= '0;
      m_last_o               <= 1'b0;
      buf_busy_o             <= '0;
      overflow_o             <= 1'b0;
    end else begin
      buf_busy_o <= busy_nxt;
      if (req_drop) overflow_o <= 1'b1;

      if (last_hs) begin
        if (pend_vld) begin
          pend_vld <= req_pend;
          if (req_pend) pend_buf <= acc_buf_sel_i;
        end
      end else if (req_pend) begin
        pend_vld <= 1'b1;
        pend_buf <= acc_buf_sel_i;
      end

      case (state)
        IDLE: begin
          if (req_start) begin
            state                  <= SEL;
            out_buf_sel_o          <= acc_buf_sel_i;
            com_unit_out_buf_sel_o <= '0;
            lat_cnt                <= '0;
          end
        end
        SEL: begin
          if (lat_cnt == LAT_END) begin
            state     <= OUT;
            m_valid_o <= 1'b1;
            m_data_o  <= out_buf_dat_i;
            m_buf_o   <= out_buf_sel_o;
            m_unit_o  <= com_unit_out_buf_sel_o;
            m_last_o  <= (com_unit_out_buf_sel_o == UNIT_LAST);
          end else begin
            lat_cnt <= lat_cnt + 2'd1;
          end
        end
        OUT: begin
          if (hs) begin
            m_valid_o <= 1'b0;
            lat_cnt   <= '0;
            if (!last_hs) begin
              com_unit_out_buf_sel_o <= com_unit_out_buf_sel_o + 1'b1;
              state                  <= SEL;
            end else if (pend_vld) begin
              out_buf_sel_o          <= pend_buf;
              com_unit_out_buf_sel_o <= '0;
              state                  <= SEL;
            end else if (req_pend) begin
              // Pend is empty, so a request arriving with the last beat starts at once.
              out_buf_sel_o          <= acc_buf_sel_i;
              com_unit_out_buf_sel_o <= '0;
              state                  <= SEL;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_out_buf_drain_ctrl.sv
// Directed bench for out_buf_drain_ctrl: stimulus queues expected beats, a negedge monitor
// pops and compares every handshake, and timeline checks cover latency, busy and overflow.
`timescale 1ns/1ps
module tb_out_buf_drain_ctrl;

  localparam int NB = 4;
  localparam int NU = 4;
  localparam int DW = 32;
  localparam int LAT = 1;

  typedef struct {
    logic [1:0]    b;
    logic [1:0]    u;
    logic [DW-1:0] d;
    logic          last;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst_i = 1'b1;
  logic          chunk_end_i = 1'b0;
  logic [1:0]    acc_buf_sel_i = '0;
  logic [1:0]    out_buf_sel_o;
  logic [1:0]    com_unit_out_buf_sel_o;
  logic [DW-1:0] out_buf_dat_i = '0;
  logic          m_valid_o;
  logic          m_ready_i = 1'b1;
  logic [DW-1:0] m_data_o;
  logic [1:0]    m_buf_o;
  logic [1:0]    m_unit_o;
  logic          m_last_o;
  logic [NB-1:0] buf_busy_o;
  logic          overflow_o;

  int    n_tests = 0;
  int    n_fail  = 0;
  beat_t exp_q[$];

  out_buf_drain_ctrl #(
    .OUTPUT_BUF_NUM(NB), .COMPUTE_UNIT_NUM(NU), .OUTPUT_BUF_SIZE(DW), .RD_LAT(LAT)
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .chunk_end_i(chunk_end_i), .acc_buf_sel_i(acc_buf_sel_i),
    .out_buf_sel_o(out_buf_sel_o), .com_unit_out_buf_sel_o(com_unit_out_buf_sel_o),
    .out_buf_dat_i(out_buf_dat_i), .m_valid_o(m_valid_o), .m_ready_i(m_ready_i),
    .m_data_o(m_data_o), .m_buf_o(m_buf_o), .m_unit_o(m_unit_o), .m_last_o(m_last_o),
    .buf_busy_o(buf_busy_o), .overflow_o(overflow_o)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] word(input logic [1:0] b, input logic [1:0] u);
    return 32'hC0DE_0005 | (32'(b) << 8) | (32'(u) << 4);
  endfunction

  // Cluster read port model: data follows the selects one cycle later.
  always @(posedge clk) out_buf_dat_i <= word(out_buf_sel_o, com_unit_out_buf_sel_o);

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_drain(input logic [1:0] b);
    for (int u = 0; u < NU; u++) begin
      beat_t e;
      e.b = b;
      e.u = 2'(u);
      e.d = word(b, 2'(u));
      e.last = (u == NU - 1);
      exp_q.push_back(e);
    end
  endtask

  always @(negedge clk) begin
    beat_t e;
    if (!rst_i && m_valid_o && m_ready_i) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected_beat", 64'(m_unit_o), 64'hFFFF);
      end else begin
        e = exp_q.pop_front();
        check("sb_buf",  64'(m_buf_o),  64'(e.b));
        check("sb_unit", 64'(m_unit_o), 64'(e.u));
        check("sb_data", 64'(m_data_o), 64'(e.d));
        check("sb_last", 64'(m_last_o), 64'(e.last));
      end
    end
  end

  task automatic all_zero(input string name);
    check({name, "_osel"},  64'(out_buf_sel_o), 0);
    check({name, "_usel"},  64'(com_unit_out_buf_sel_o), 0);
    check({name, "_valid"}, 64'(m_valid_o), 0);
    check({name, "_data"},  64'(m_data_o), 0);
    check({name, "_mbuf"},  64'(m_buf_o), 0);
    check({name, "_munit"}, 64'(m_unit_o), 0);
    check({name, "_last"},  64'(m_last_o), 0);
    check({name, "_busy"},  64'(buf_busy_o), 0);
    check({name, "_ovf"},   64'(overflow_o), 0);
  endtask

  task automatic apply_reset(input string name);
    @(negedge clk);
    rst_i = 1'b1;
    chunk_end_i = 1'b0;
    exp_q.delete();
    repeat (2) @(negedge clk);
    all_zero(name);
    rst_i = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    bit done = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      chunk_end_i = 1'b0;
      if (!m_valid_o && buf_busy_o == '0 && exp_q.size() == 0) begin
        done = 1'b1;
        break;
      end
    end
    check({name, "_drained"}, 64'(done), 1);
    check({name, "_sb_left"}, 64'(exp_q.size()), 0);
  endtask

  task automatic req(input logic [1:0] b, input bit expect_ok);
    chunk_end_i = 1'b1;
    acc_buf_sel_i = b;
    if (expect_ok) push_drain(b);
  endtask

  // Single buffer: first beat two edges after the sampling edge, then one every three.
  task automatic test_single();
    @(negedge clk);
    req(2'd2, 1'b1);
    for (int k = 0; k <= 13; k++) begin
      @(negedge clk);
      chunk_end_i = 1'b0;
      check($sformatf("t1_valid_k%0d", k), 64'(m_valid_o), 64'((k % 3 == 2) && (k <= 11)));
      check($sformatf("t1_busy_k%0d", k), 64'(buf_busy_o), (k <= 11) ? 64'h4 : 64'h0);
    end
    wait_idle("t1");
  endtask

  task automatic test_backpressure();
    bit found = 1'b0;
    @(negedge clk);
    req(2'd1, 1'b1);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chunk_end_i = 1'b0;
      if (m_valid_o && m_unit_o == 2'd0) begin
        found = 1'b1;
        break;
      end
    end
    check("t2_beat0_seen", 64'(found), 1);
    @(posedge clk);
    #1 m_ready_i = 1'b0;
    for (int j = 0; j < 12; j++) begin
      @(negedge clk);
      if (j >= 2) begin
        check("t2_hold_valid", 64'(m_valid_o), 1);
        check("t2_hold_unit",  64'(m_unit_o), 1);
        check("t2_hold_data",  64'(m_data_o), 64'(word(2'd1, 2'd1)));
        check("t2_hold_osel",  64'(out_buf_sel_o), 1);
        check("t2_hold_usel",  64'(com_unit_out_buf_sel_o), 1);
      end
    end
    @(posedge clk);
    #1 m_ready_i = 1'b1;
    wait_idle("t2");
  endtask

  task automatic test_pend(input bit third);
    @(negedge clk);
    req(2'd0, 1'b1);
    for (int k = 0; k <= 14; k++) begin
      @(negedge clk);
      chunk_end_i = 1'b0;
      if (k == 1) req(2'd1, 1'b1);
      if (k == 3 && third) req(2'd2, 1'b0);
      if (k == 2) check("t3_busy_overlap", 64'(buf_busy_o), 64'h3);
      if (k == 3) check("t3_ovf_before", 64'(overflow_o), 0);
      if (k == 4 && third) begin
        check("t4_ovf_set", 64'(overflow_o), 1);
        check("t4_busy", 64'(buf_busy_o), 64'h3);
      end
      if (third) check("t4_bit2_clear", 64'(buf_busy_o[2]), 0);
      if (k == 11) begin
        check("t3_last0_buf", 64'(m_buf_o), 0);
        check("t3_last0_unit", 64'(m_unit_o), 3);
      end
      if (k == 12) begin
        check("t3_busy_after0", 64'(buf_busy_o), 64'h2);
        check("t3_osel_next", 64'(out_buf_sel_o), 1);
        check("t3_valid_gap", 64'(m_valid_o), 0);
      end
      if (k == 14) begin
        check("t3_next_valid", 64'(m_valid_o), 1);
        check("t3_next_buf", 64'(m_buf_o), 1);
      end
    end
    wait_idle(third ? "t4" : "t3");
    check(third ? "t4_ovf_sticky" : "t3_ovf", 64'(overflow_o), 64'(third));
  endtask

  task automatic test_same_cycle();
    @(negedge clk);
    req(2'd0, 1'b1);
    for (int k = 0; k <= 14; k++) begin
      @(negedge clk);
      chunk_end_i = 1'b0;
      if (k == 11) req(2'd3, 1'b1);
      if (k == 12) begin
        check("t5_busy", 64'(buf_busy_o), 64'h8);
        check("t5_osel", 64'(out_buf_sel_o), 3);
        check("t5_usel", 64'(com_unit_out_buf_sel_o), 0);
        check("t5_ovf", 64'(overflow_o), 0);
      end
      if (k == 14) check("t5_valid", 64'(m_valid_o), 1);
    end
    wait_idle("t5");
    check("t5_ovf_end", 64'(overflow_o), 0);
  endtask

  task automatic test_mid_reset();
    @(negedge clk);
    req(2'd1, 1'b1);
    for (int k = 0; k <= 7; k++) begin
      @(negedge clk);
      chunk_end_i = 1'b0;
      if (k == 6) begin
        check("t6_in_sel_unit2", 64'(com_unit_out_buf_sel_o), 2);
        rst_i = 1'b1;
        req(2'd3, 1'b0);
      end
    end
    all_zero("t6_reset");
    check("t6_sb_remaining", 64'(exp_q.size()), 2);
    exp_q.delete();
    rst_i = 1'b0;
    chunk_end_i = 1'b0;
    @(negedge clk);
    req(2'd2, 1'b1);
    wait_idle("t6_after");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    all_zero("reset");
    rst_i = 1'b0;
    test_single();
    test_backpressure();
    test_pend(1'b0);
    test_pend(1'b1);
    apply_reset("t4_clear");
    test_same_cycle();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
